// File: rtl/request_distributor.sv
// ============================================================================
// request_distributor
// ----------------------------------------------------------------------------
// Purpose:
//   Takes one valid/ack request stream in which every beat carries a
//   destination index, and sends each beat to one of NUM_REQUEST output
//   ports. Each output port has its own small FIFO. When one consumer stalls,
//   only the beats addressed to that port are held back. Beats addressed to
//   other ports keep moving. This block usually sits on the response path
//   back to the requesters that an N-to-1 arbiter merged.
//
// Ports:
//   clk_in                    - clock; all state updates on the rising edge
//   reset_in                  - asynchronous, active-high reset
//   request_in                - incoming payload (W bits)
//   request_dest_in           - destination port index for request_in
//   request_valid_in          - incoming beat valid
//   issue_ack_out             - combinational; beat accepted at this edge
//   request_flatted_out       - head of FIFO i in slice [i*W +: W], zero if empty
//   request_valid_flatted_out - bit i set while FIFO i is non-empty
//   issue_ack_flatted_in      - bit i: consumer i takes the head of FIFO i
//   queue_full_flatted_out    - bit i set while FIFO i holds OUTPUT_QUEUE_SIZE
//   dest_error_out            - registered one-cycle pulse: out-of-range beat
//                               was dropped
// ============================================================================
module request_distributor #(
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int NUM_REQUEST                  = 3,
    parameter int OUTPUT_QUEUE_SIZE            = 2,
    parameter int NUM_REQUEST_LOG2             = $clog2(NUM_REQUEST)
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_in,
    input  logic [NUM_REQUEST_LOG2-1:0]                         request_dest_in,
    input  logic                                                request_valid_in,
    output logic                                                issue_ack_out,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_out,
    output logic [NUM_REQUEST-1:0]                              request_valid_flatted_out,
    input  logic [NUM_REQUEST-1:0]                              issue_ack_flatted_in,
    output logic [NUM_REQUEST-1:0]                              queue_full_flatted_out,
    output logic                                                dest_error_out
);

    localparam int W     = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam int PTR_W = $clog2(OUTPUT_QUEUE_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(OUTPUT_QUEUE_SIZE);

    logic                   dest_in_range;
    logic                   dest_full;
    logic                   accept;
    logic [NUM_REQUEST-1:0] queue_full;

    // The compare uses one extra bit so that it stays correct when
    // NUM_REQUEST is an exact power of two. In that case every index value
    // that fits in the field is in range.
    assign dest_in_range = ({1'b0, request_dest_in} < (NUM_REQUEST_LOG2 + 1)'(NUM_REQUEST));

    // Pick the full flag of the addressed FIFO. The loop only matches legal
    // indices, so an out-of-range destination never indexes past the array.
    // Such a beat always sees "not full" and is simply dropped.
    always_comb begin
        dest_full = 1'b0;
        for (int i = 0; i < NUM_REQUEST; i++) begin
            if (request_dest_in == NUM_REQUEST_LOG2'(i)) begin
                dest_full = queue_full[i];
            end
        end
    end

    // Acceptance does not depend on a pop in the same cycle. A full FIFO
    // refuses the beat even when its head leaves at this edge. This keeps the
    // ack path free of the consumer-side ack.
    assign issue_ack_out = request_valid_in & (~dest_in_range | ~dest_full);
    assign accept        = request_valid_in & issue_ack_out;

    // An out-of-range beat is acked and discarded. The error flag is
    // registered so that it shows up as a one-cycle pulse in the cycle after
    // the drop.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            dest_error_out <= 1'b0;
        end else begin
            dest_error_out <= accept & ~dest_in_range;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REQUEST; g++) begin : g_fifo
            logic [W-1:0]     mem [OUTPUT_QUEUE_SIZE];
            logic [PTR_W-1:0] wr_ptr;
            logic [PTR_W-1:0] rd_ptr;
            logic [CNT_W-1:0] count;
            logic             push;
            logic             pop;

            assign push = accept & dest_in_range &
                          (request_dest_in == NUM_REQUEST_LOG2'(g));
            assign pop  = issue_ack_flatted_in[g] & (count != '0);

            // Pointer and occupancy bookkeeping. The pointers are exactly
            // log2(depth) bits wide, so they wrap on their own. A push and a
            // pop at the same edge move both pointers and leave the count
            // unchanged, so valid stays high without a bubble.
            always_ff @(posedge clk_in or posedge reset_in) begin
                if (reset_in) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                    case ({push, pop})
                        2'b10:   count <= count + CNT_W'(1);
                        2'b01:   count <= count - CNT_W'(1);
                        default: count <= count;
                    endcase
                end
            end

            // The storage array has no reset. After a reset the pointers and
            // the count return to zero, so any old contents can never reach
            // the output. The output is forced to zero while the count is
            // zero.
            always_ff @(posedge clk_in) begin
                if (push) begin
                    mem[wr_ptr] <= request_in;
                end
            end

            assign request_valid_flatted_out[g] = (count != '0);
            assign queue_full[g]                = (count == FULL_COUNT);
            assign request_flatted_out[g*W +: W] = (count != '0) ? mem[rd_ptr] : '0;
        end
    endgenerate

    assign queue_full_flatted_out = queue_full;

endmodule

// File: tb/tb_request_distributor.sv
// ============================================================================
// tb_request_distributor
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for request_distributor with W=64, N=3, depth 2.
//   A table of per-cycle vectors holds the inputs for each cycle and the
//   outputs expected during that cycle, before the next rising edge.
//   Hand-written sequences cover the long push/pop stream and the
//   asynchronous reset asserted between clock edges.
//
// Ports:
//   none (top-level bench)
// ============================================================================
module tb_request_distributor;

    localparam int W  = 64;
    localparam int N  = 3;
    localparam int D  = 2;
    localparam int DL = 2;

    logic             clk_in = 1'b0;
    logic             reset_in;
    logic [W-1:0]     request_in;
    logic [DL-1:0]    request_dest_in;
    logic             request_valid_in;
    logic             issue_ack_out;
    logic [W*N-1:0]   request_flatted_out;
    logic [N-1:0]     request_valid_flatted_out;
    logic [N-1:0]     issue_ack_flatted_in;
    logic [N-1:0]     queue_full_flatted_out;
    logic             dest_error_out;

    int tests_run    = 0;
    int tests_failed = 0;

    request_distributor #(
        .SINGLE_REQUEST_WIDTH_IN_BITS(W),
        .NUM_REQUEST(N),
        .OUTPUT_QUEUE_SIZE(D),
        .NUM_REQUEST_LOG2(DL)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .request_in(request_in),
        .request_dest_in(request_dest_in),
        .request_valid_in(request_valid_in),
        .issue_ack_out(issue_ack_out),
        .request_flatted_out(request_flatted_out),
        .request_valid_flatted_out(request_valid_flatted_out),
        .issue_ack_flatted_in(issue_ack_flatted_in),
        .queue_full_flatted_out(queue_full_flatted_out),
        .dest_error_out(dest_error_out)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk_in = ~clk_in;

    // Each record holds the inputs for one cycle and the outputs expected
    // before the rising edge that ends that cycle.
    typedef struct {
        logic [W-1:0]   payload;
        logic [DL-1:0]  dest;
        logic           valid;
        logic [N-1:0]   acks;
        logic           exp_ack;
        logic [N-1:0]   exp_valid;
        logic [N-1:0]   exp_full;
        logic           exp_err;
        logic [W*N-1:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [W-1:0] payload, input logic [DL-1:0] dest,
                                input logic valid, input logic [N-1:0] acks,
                                input logic exp_ack, input logic [N-1:0] exp_valid,
                                input logic [N-1:0] exp_full, input logic exp_err,
                                input logic [W*N-1:0] exp_data);
        vec_t v;
        v.payload   = payload;
        v.dest      = dest;
        v.valid     = valid;
        v.acks      = acks;
        v.exp_ack   = exp_ack;
        v.exp_valid = exp_valid;
        v.exp_full  = exp_full;
        v.exp_err   = exp_err;
        v.exp_data  = exp_data;
        return v;
    endfunction

    function automatic logic [W*N-1:0] dat(input logic [W-1:0] s0, input logic [W-1:0] s1,
                                           input logic [W-1:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic drive(input logic [W-1:0] payload, input logic [DL-1:0] dest,
                         input logic valid, input logic [N-1:0] acks);
        request_in           = payload;
        request_dest_in      = dest;
        request_valid_in     = valid;
        issue_ack_flatted_in = acks;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.payload, v.dest, v.valid, v.acks);
    endtask

    task automatic checkOutput(input string name, input logic [W*N-1:0] got,
                               input logic [W*N-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("row%0d issue_ack", idx), (W*N)'(issue_ack_out), (W*N)'(v.exp_ack));
        checkOutput($sformatf("row%0d valid", idx), (W*N)'(request_valid_flatted_out), (W*N)'(v.exp_valid));
        checkOutput($sformatf("row%0d full", idx), (W*N)'(queue_full_flatted_out), (W*N)'(v.exp_full));
        checkOutput($sformatf("row%0d dest_error", idx), (W*N)'(dest_error_out), (W*N)'(v.exp_err));
        checkOutput($sformatf("row%0d data", idx), request_flatted_out, v.exp_data);
    endtask

    // Hard bound on total run time, in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_in = 1'b1;
        drive('0, '0, 1'b0, '0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("reset valid", (W*N)'(request_valid_flatted_out), '0);
        checkOutput("reset full", (W*N)'(queue_full_flatted_out), '0);
        checkOutput("reset dest_error", (W*N)'(dest_error_out), '0);
        checkOutput("reset data", request_flatted_out, '0);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;

        // One beat to each port on back-to-back cycles, all consumers ready.
        vecs.push_back(mk(64'hA0, 2'd0, 1, 3'b111, 1, 3'b000, 3'b000, 0, '0));
        vecs.push_back(mk(64'hA1, 2'd1, 1, 3'b111, 1, 3'b001, 3'b000, 0, dat(64'hA0, 0, 0)));
        vecs.push_back(mk(64'hA2, 2'd2, 1, 3'b111, 1, 3'b010, 3'b000, 0, dat(0, 64'hA1, 0)));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b111, 0, 3'b100, 3'b000, 0, dat(0, 0, 64'hA2)));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b000, 0, 3'b000, 3'b000, 0, '0));
        // Consumer 1 stalls. B2 is held while port 1 is full and C0 waits.
        vecs.push_back(mk(64'hB0, 2'd1, 1, 3'b101, 1, 3'b000, 3'b000, 0, '0));
        vecs.push_back(mk(64'hB1, 2'd1, 1, 3'b101, 1, 3'b010, 3'b000, 0, dat(0, 64'hB0, 0)));
        vecs.push_back(mk(64'hB2, 2'd1, 1, 3'b101, 0, 3'b010, 3'b010, 0, dat(0, 64'hB0, 0)));
        vecs.push_back(mk(64'hB2, 2'd1, 1, 3'b101, 0, 3'b010, 3'b010, 0, dat(0, 64'hB0, 0)));
        vecs.push_back(mk(64'hB2, 2'd1, 1, 3'b111, 0, 3'b010, 3'b010, 0, dat(0, 64'hB0, 0)));
        vecs.push_back(mk(64'hB2, 2'd1, 1, 3'b111, 1, 3'b010, 3'b000, 0, dat(0, 64'hB1, 0)));
        vecs.push_back(mk(64'hC0, 2'd0, 1, 3'b111, 1, 3'b010, 3'b000, 0, dat(0, 64'hB2, 0)));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b111, 0, 3'b001, 3'b000, 0, dat(64'hC0, 0, 0)));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b000, 0, 3'b000, 3'b000, 0, '0));
        // Port 2 full, its consumer pops while D2 waits: count 2 -> 1 -> 2.
        vecs.push_back(mk(64'hD0, 2'd2, 1, 3'b000, 1, 3'b000, 3'b000, 0, '0));
        vecs.push_back(mk(64'hD1, 2'd2, 1, 3'b000, 1, 3'b100, 3'b000, 0, dat(0, 0, 64'hD0)));
        vecs.push_back(mk(64'hD2, 2'd2, 1, 3'b100, 0, 3'b100, 3'b100, 0, dat(0, 0, 64'hD0)));
        vecs.push_back(mk(64'hD2, 2'd2, 1, 3'b000, 1, 3'b100, 3'b000, 0, dat(0, 0, 64'hD1)));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b000, 0, 3'b100, 3'b100, 0, dat(0, 0, 64'hD1)));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b100, 0, 3'b100, 3'b100, 0, dat(0, 0, 64'hD1)));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b100, 0, 3'b100, 3'b000, 0, dat(0, 0, 64'hD2)));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b000, 0, 3'b000, 3'b000, 0, '0));
        // Out-of-range destination: acked, dropped, one-cycle error pulse.
        vecs.push_back(mk(64'hDEAD, 2'd3, 1, 3'b000, 1, 3'b000, 3'b000, 0, '0));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b000, 0, 3'b000, 3'b000, 1, '0));
        vecs.push_back(mk(64'h00, 2'd0, 0, 3'b000, 0, 3'b000, 3'b000, 0, '0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk_in);
            checkVector(i, vecs[i]);
            @(posedge clk_in);
            #1;
        end

        // Streaming on port 0 with one entry resident: push and pop every
        // cycle, so the pointers wrap several times and valid never drops.
        drive(64'h00, 2'd0, 1'b1, 3'b000);
        @(negedge clk_in);
        checkOutput("stream preload ack", (W*N)'(issue_ack_out), (W*N)'(1'b1));
        @(posedge clk_in);
        #1;
        for (int k = 1; k < 10; k++) begin
            drive(W'(k), 2'd0, 1'b1, 3'b001);
            @(negedge clk_in);
            checkOutput($sformatf("stream%0d ack", k), (W*N)'(issue_ack_out), (W*N)'(1'b1));
            checkOutput($sformatf("stream%0d valid", k), (W*N)'(request_valid_flatted_out), (W*N)'(3'b001));
            checkOutput($sformatf("stream%0d data", k), request_flatted_out, dat(W'(k - 1), 0, 0));
            @(posedge clk_in);
            #1;
        end
        drive('0, '0, 1'b0, 3'b001);
        @(negedge clk_in);
        checkOutput("stream tail data", request_flatted_out, dat(64'h09, 0, 0));
        checkOutput("stream tail valid", (W*N)'(request_valid_flatted_out), (W*N)'(3'b001));
        @(posedge clk_in);
        #1;
        drive('0, '0, 1'b0, 3'b000);
        @(negedge clk_in);
        checkOutput("stream drained valid", (W*N)'(request_valid_flatted_out), '0);
        @(posedge clk_in);
        #1;

        // Asynchronous reset asserted between edges while ports 0 and 1
        // hold data.
        drive(64'hE0, 2'd0, 1'b1, 3'b000);
        @(posedge clk_in);
        #1;
        drive(64'hE1, 2'd1, 1'b1, 3'b000);
        @(posedge clk_in);
        #1;
        drive('0, '0, 1'b0, 3'b000);
        @(negedge clk_in);
        checkOutput("pre-reset valid", (W*N)'(request_valid_flatted_out), (W*N)'(3'b011));
        #2;
        reset_in = 1'b1;
        #1;
        checkOutput("async reset valid", (W*N)'(request_valid_flatted_out), '0);
        checkOutput("async reset full", (W*N)'(queue_full_flatted_out), '0);
        checkOutput("async reset data", request_flatted_out, '0);
        @(negedge clk_in);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;
        drive(64'hF0, 2'd1, 1'b1, 3'b000);
        @(negedge clk_in);
        checkOutput("post-reset ack", (W*N)'(issue_ack_out), (W*N)'(1'b1));
        @(posedge clk_in);
        #1;
        drive('0, '0, 1'b0, 3'b000);
        @(negedge clk_in);
        checkOutput("post-reset valid", (W*N)'(request_valid_flatted_out), (W*N)'(3'b010));
        checkOutput("post-reset data", request_flatted_out, dat(0, 64'hF0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
